// File: rtl/mult_div_pkg.sv
// mult_div_pkg: op encodings, FSM state type and small op
// decode helpers shared by the multiply/divide unit files.
package mult_div_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 0,
      OP_MULTU = 1,
      OP_DIV   = 2,
      OP_DIVU  = 3
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

   function automatic logic op_is_div(op_e o);
      return o[1];
   endfunction

   function automatic logic op_is_signed(op_e o);
      return ~o[0];
   endfunction

endpackage

// File: rtl/mdu_sign_conv.sv
// mdu_sign_conv: conditional two's-complement negate.
// Ports: val_i value, neg_i negate enable, res_o result.
module mdu_sign_conv
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] res_o
);

   assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and divide.
// Ports: clk, reset (sync, active-low), start/op/a/b request,
// busy, done pulse, div_zero flag, hi/lo result registers.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             neg_lo_q, neg_lo_d;
   logic             neg_hi_q, neg_hi_d;
   logic             busy_q, done_q;
   logic             dz_q, dz_d;

   op_e              op_in;
   logic             sgn_a, sgn_b;
   logic             in_fix, is_div;
   logic [WIDTH-1:0] ca_in, ca_out;
   logic [WIDTH-1:0] cb_in, cb_out;
   logic             ca_neg, cb_neg;

   assign op_in = op_e'(op);
   assign sgn_a = op_is_signed(op_in) & a[WIDTH-1];
   assign sgn_b = op_is_signed(op_in) & b[WIDTH-1];
   assign in_fix = (state_q == FIX);
   assign is_div = op_is_div(op_q);

   // The two negators take a/b magnitudes in IDLE and are
   // reused for the quotient/remainder or product fix-up in FIX.
   assign ca_in  = in_fix ? acc_lo_q : a;
   assign ca_neg = in_fix ? neg_lo_q : sgn_a;
   assign cb_in  = in_fix ? acc_hi_q : b;
   assign cb_neg = in_fix ? neg_hi_q : sgn_b;

   mdu_sign_conv #(.WIDTH(WIDTH)) u_conv_a (
      .val_i (ca_in),
      .neg_i (ca_neg),
      .res_o (ca_out)
   );

   mdu_sign_conv #(.WIDTH(WIDTH)) u_conv_b (
      .val_i (cb_in),
      .neg_i (cb_neg),
      .res_o (cb_out)
   );

   // Shared adder. Multiply: acc_hi + (lsb ? mcand : 0).
   // Divide: shifted remainder - divisor via ~d + 1.
   logic [WIDTH:0] add_x, add_y, sum, rem_sh;
   logic           add_cin, fits;

   assign rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};

   always_comb begin
      add_x   = {1'b0, acc_hi_q};
      add_y   = '0;
      add_cin = 1'b0;
      if (is_div) begin
         add_x   = rem_sh;
         add_y   = ~{1'b0, opnd_q};
         add_cin = 1'b1;
      end else if (acc_lo_q[0]) begin
         add_y = {1'b0, opnd_q};
      end
   end

   assign sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};

   // remainder < divisor keeps rem_sh < 2*divisor, so a set
   // top bit always fits, otherwise the difference sign decides.
   assign fits = rem_sh[WIDTH] | ~sum[WIDTH];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      dz_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d = op_in;
               if (op_is_div(op_in) && (b == '0)) begin
                  state_d = DONE;
                  dz_d    = 1'b1;
               end else begin
                  state_d  = CALC;
                  cnt_d    = '0;
                  acc_hi_d = '0;
                  if (op_is_div(op_in)) begin
                     acc_lo_d = ca_out;
                     opnd_d   = cb_out;
                     neg_hi_d = sgn_a;
                  end else begin
                     acc_lo_d = cb_out;
                     opnd_d   = ca_out;
                     neg_hi_d = sgn_a ^ sgn_b;
                  end
                  neg_lo_d = sgn_a ^ sgn_b;
               end
            end
         end
         CALC: begin
            if (is_div) begin
               acc_hi_d = fits ? sum[WIDTH-1:0]
                               : rem_sh[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], fits};
            end else begin
               acc_hi_d = sum[WIDTH:1];
               acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            lo_d = ca_out;
            // -{H,L} = {~H, -L} unless L is zero.
            if (!is_div && neg_hi_q && (acc_lo_q != '0)) begin
               hi_d = ~acc_hi_q;
            end else begin
               hi_d = cb_out;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         op_q     <= OP_MULT;
         cnt_q    <= '0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         opnd_q   <= opnd_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         busy_q   <= (state_d != IDLE);
         done_q   <= (state_d == DONE);
         dz_q     <= dz_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit at
// WIDTH=32 (directed cases) and WIDTH=8 (random sweep).
module tb_mult_div_unit;
   import mult_div_pkg::*;

   typedef struct {
      int          d;
      logic        dz;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      int          e;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic [1:0]  op0 = '0, op1 = '0;
   logic [31:0] a0 = '0, b0 = '0;
   logic [7:0]  a1 = '0, b1 = '0;
   logic        busy0, done0, dz0;
   logic        busy1, done1, dz1;
   logic [31:0] hi0, lo0;
   logic [7:0]  hi1, lo1;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset_n), .start(start0), .op(op0),
      .a(a0), .b(b0), .busy(busy0), .done(done0),
      .div_zero(dz0), .hi(hi0), .lo(lo0)
   );

   mult_div_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset_n), .start(start1), .op(op1),
      .a(a1), .b(b1), .busy(busy1), .done(done1),
      .div_zero(dz1), .hi(hi1), .lo(lo1)
   );

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   exp_t        q[$];
   logic [31:0] mhi[2] = '{default: '0};
   logic [31:0] mlo[2] = '{default: '0};
   logic [31:0] last_hi[2] = '{default: '0};
   logic [31:0] last_lo[2] = '{default: '0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // Reference: plain integer arithmetic on sign/zero-extended values.
   task automatic ref_model(int w, logic [1:0] o, logic [31:0] av,
                            logic [31:0] bv, logic [31:0] ph,
                            logic [31:0] pl, output logic [31:0] h,
                            output logic [31:0] l, output logic dz);
      longint m, sa, sb, p;
      logic   sg;
      m  = (longint'(1) << w) - 1;
      sg = (o == OP_MULT) || (o == OP_DIV);
      sa = longint'(av) & m;
      sb = longint'(bv) & m;
      if (sg && av[w-1]) sa = sa - (longint'(1) << w);
      if (sg && bv[w-1]) sb = sb - (longint'(1) << w);
      dz = 1'b0;
      if (o == OP_MULT || o == OP_MULTU) begin
         p = sa * sb;
         h = 32'((p >>> w) & m);
         l = 32'(p & m);
      end else if (sb == 0) begin
         h  = ph;
         l  = pl;
         dz = 1'b1;
      end else begin
         h = 32'((sa % sb) & m);
         l = 32'((sa / sb) & m);
      end
   endtask

   function automatic logic dn(int d);
      return (d == 0) ? done0 : done1;
   endfunction

   function automatic logic bz(int d);
      return (d == 0) ? busy0 : busy1;
   endfunction

   task automatic set_start(int d, logic s);
      if (d == 0) start0 = s;
      else start1 = s;
   endtask

   task automatic drive(int d, logic [1:0] o, logic [31:0] av,
                        logic [31:0] bv);
      if (d == 0) begin
         op0 = o; a0 = av; b0 = bv;
      end else begin
         op1 = o; a1 = av[7:0]; b1 = bv[7:0];
      end
      set_start(d, 1'b1);
   endtask

   task automatic junk(int d);
      logic [31:0] bv;
      bv = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      drive(d, 2'($urandom_range(0, 3)), $urandom, bv);
   endtask

   task automatic issue(int d, logic [1:0] o, logic [31:0] av,
                        logic [31:0] bv);
      exp_t e;
      int   w;
      w = (d == 0) ? 32 : 8;
      ref_model(w, o, av, bv, mhi[d], mlo[d], e.hi, e.lo, e.dz);
      e.d   = d;
      e.lat = e.dz ? 1 : w + 2;
      e.e   = cyc + 1;
      mhi[d] = e.hi;
      mlo[d] = e.lo;
      q.push_back(e);
      drive(d, o, av, bv);
   endtask

   task automatic wait_done(int d, bit jm, bit jd);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (!seen) begin
         @(negedge clk);
         n++;
         set_start(d, 1'b0);
         if (dn(d)) begin
            seen = 1;
            if (jd) junk(d);
         end else if (n > 64) begin
            total++;
            bad++;
            $display("FAIL timeout dut=%0d", d);
            seen = 1;
         end else if (jm && n == 2 && bz(d)) begin
            junk(d);
         end
      end
      @(negedge clk);
      set_start(d, 1'b0);
   endtask

   task automatic mon(int d, logic dnv, logic dzv, logic [31:0] h,
                      logic [31:0] l);
      exp_t e;
      if (dnv) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done dut=%0d", d);
         end else begin
            e = q.pop_front();
            chk("dut_sel", 64'(d), 64'(e.d));
            chk("hi", 64'(h), 64'(e.hi));
            chk("lo", 64'(l), 64'(e.lo));
            chk("div_zero", 64'(dzv), 64'(e.dz));
            chk("latency", 64'(cyc - e.e + 1), 64'(e.lat));
            last_hi[d] = e.hi;
            last_lo[d] = e.lo;
         end
      end else begin
         chk("dz_no_done", 64'(dzv), 64'(0));
         chk("hold_hi", 64'(h), 64'(last_hi[d]));
         chk("hold_lo", 64'(l), 64'(last_lo[d]));
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         mon(0, done0, dz0, hi0, lo0);
         mon(1, done1, dz1, {24'h0, hi1}, {24'h0, lo1});
      end
   end

   initial begin
      logic [31:0] av, bv;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy0), 64'(0));
      chk("rst_done", 64'(done0), 64'(0));
      chk("rst_dz", 64'(dz0), 64'(0));
      chk("rst_hi", 64'(hi0), 64'(0));
      chk("rst_lo", 64'(lo0), 64'(0));
      chk("rst_busy8", 64'(busy1), 64'(0));
      reset_n = 1'b1;
      @(negedge clk);

      issue(0, OP_MULT, 32'hFFFFFFFD, 32'd7);
      wait_done(0, 0, 0);
      chk("mult_hi", 64'(hi0), 64'hFFFFFFFF);
      chk("mult_lo", 64'(lo0), 64'hFFFFFFEB);

      issue(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(0, 0, 1);
      chk("multu_hi", 64'(hi0), 64'hFFFFFFFE);
      chk("multu_lo", 64'(lo0), 64'h00000001);

      issue(0, OP_DIV, 32'hFFFFFFF9, 32'd2);
      wait_done(0, 0, 0);
      chk("div_lo", 64'(lo0), 64'hFFFFFFFD);
      chk("div_hi", 64'(hi0), 64'hFFFFFFFF);

      issue(0, OP_DIVU, 32'd7, 32'd2);
      wait_done(0, 0, 0);
      chk("divu_lo", 64'(lo0), 64'd3);
      chk("divu_hi", 64'(hi0), 64'd1);

      issue(0, OP_DIV, 32'd5, 32'd0);
      wait_done(0, 0, 0);
      chk("dz_hi", 64'(hi0), 64'd1);
      chk("dz_lo", 64'(lo0), 64'd3);

      issue(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done(0, 0, 0);
      chk("ovf_lo", 64'(lo0), 64'h80000000);
      chk("ovf_hi", 64'(hi0), 64'd0);

      issue(0, OP_MULT, 32'h12345678, 32'h9ABCDEF1);
      wait_done(0, 1, 1);

      for (int i = 0; i < 40; i++) begin
         av = $urandom;
         bv = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         issue(0, 2'($urandom_range(0, 3)), av, bv);
         wait_done(0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0);
      end

      issue(0, OP_MULTU, 32'hDEADBEEF, 32'h01234567);
      @(negedge clk);
      set_start(0, 1'b0);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(busy0), 64'(0));
      chk("midrst_done", 64'(done0), 64'(0));
      chk("midrst_hi", 64'(hi0), 64'(0));
      chk("midrst_lo", 64'(lo0), 64'(0));
      q.delete();
      for (int d = 0; d < 2; d++) begin
         mhi[d] = '0; mlo[d] = '0;
         last_hi[d] = '0; last_lo[d] = '0;
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 300; i++) begin
         av = $urandom;
         bv = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin
            av = 32'h80;
            bv = 32'hFF;
         end
         issue(1, 2'($urandom_range(0, 3)), av, bv);
         wait_done(1, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0);
      end

      repeat (4) @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width; SHALL be even and at least 8.
REQ-002 Port: clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 Port: reset  input  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start.
REQ-006 Port: a  input  WIDTH  multiplicand or dividend; sampled with start.
REQ-007 Port: b  input  WIDTH  multiplier or divisor; sampled with start.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: div_zero  output  1  high with done when a DIV/DIVU had b==0; low otherwise.
REQ-011 Port: hi  output  WIDTH  HI register: product upper half or remainder.
REQ-012 Port: lo  output  WIDTH  LO register: product lower half or quotient.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-014 IDLE -> CALC when start=1: latch op, |a|, |b| (magnitudes only for signed ops) and the result sign bits, and clear the iteration counter.
REQ-015 Exception to REQ-014: IDLE -> DONE directly when start=1, op[1]=1 and b==0.
REQ-016 CALC SHALL perform exactly WIDTH iterations, one per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide.
REQ-017 CALC -> FIX after the iteration with counter == WIDTH-1.
REQ-018 FIX SHALL last one cycle, negate the results as required by the latched signs, and load hi/lo on exit; FIX -> DONE.
REQ-019 DONE SHALL last one cycle with done=1; DONE -> IDLE.
REQ-020 Latency: done SHALL be high exactly WIDTH+2 cycles after the start-sampling edge; a divide-by-zero request completes in 1 cycle.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-022 start in the DONE cycle SHALL be ignored; a new request is accepted the following cycle.
REQ-023 MULT/MULTU: {hi,lo} SHALL equal the exact 2*WIDTH-bit signed/unsigned product.
REQ-024 DIV/DIVU: lo SHALL be the quotient, truncated toward zero; hi SHALL be the remainder, with the sign of the dividend.
REQ-025 Signed DIV of the most-negative value by -1: lo SHALL be the most-negative value (wrap) and hi SHALL be 0, with no flag.
REQ-026 Divide by zero: hi and lo SHALL hold their previous values, and div_zero=1 for the done cycle.
REQ-027 hi and lo SHALL change only on FIX exit and SHALL hold between operations; intermediate values SHALL never appear on hi/lo.
REQ-028 div_zero SHALL be low whenever done is low.

Reset
REQ-029 reset=0 at a clk edge SHALL force IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, and clear the counter and operand registers, including mid-CALC/FIX/DONE.
REQ-030 Reset SHALL take priority over start; start SHALL be honoured no earlier than the first edge with reset=1.

Structure
REQ-031 A shared package mult_div_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state enum.
REQ-032 The counter width SHALL be derived as clog2(WIDTH)+1; no width literal other than WIDTH SHALL appear in the RTL.
REQ-033 One combinational sub-module, mdu_sign_conv (conditional two's-complement negate, WIDTH-parameterised), SHALL be instanced for operand magnitude and result fix-up.
REQ-034 The datapath SHALL use one WIDTH+1-bit adder/subtractor shared by multiply and divide.

Verification
REQ-035 WIDTH=32, MULT a=-3 (0xFFFFFFFD), b=7 -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-036 WIDTH=32, MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 WIDTH=32, DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIVU a=7, b=2 -> lo=3, hi=1.
REQ-038 DIV a=5, b=0 after an earlier result of hi=1, lo=3 -> done one cycle after start, div_zero=1, hi=1, lo=3 unchanged.
REQ-039 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-040 Pulse start mid-CALC (ignored, result unaffected); in a second run, assert reset=0 mid-CALC -> next edge shows IDLE, busy=0, hi=lo=0, and no done pulse; parameter sweep WIDTH=8 with random ops checked against a reference model, including latency WIDTH+2.
